// File: rtl/swclk_pkg.sv
// Shared switch clock definitions: FSM state type and default timing constants
// used by both the switch clock generator and the receive-side monitor.
package swclk_pkg;

   typedef enum logic {
      SEARCH  = 1'b0,
      MEASURE = 1'b1
   } swclk_state_t;

   localparam int SWCLK_NOMINAL_PERIOD = 48000;
   localparam int SWCLK_TOLERANCE      = 480;
   localparam int SWCLK_TIMEOUT        = 96000;
   localparam int SWCLK_CNT_W          = 17;

endpackage

// File: rtl/swclk_sync_filter.sv
// Synchronizer, optional glitch filter (SWCLK_GLITCH_FILTER_EN) and edge detect
// for the switch clock. Ports: clk, clr_n, sw_clk_in in; rise, fall pulses out.
module swclk_sync_filter
   import swclk_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 8
) (
   input  logic clk,
   input  logic clr_n,
   input  logic sw_clk_in,
   output logic rise,
   output logic fall
);

   if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_cfg
      $error("swclk_sync_filter: SYNC_STAGES must be >= 2, FILTER_LEN >= 1");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic                   level;
   logic                   level_q;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sw_clk_in};
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

`ifdef SWCLK_GLITCH_FILTER_EN
   localparam int FW = $clog2(FILTER_LEN + 1);

   logic [FW-1:0] flt_cnt;
   logic          filt_q;

   // flt_cnt counts consecutive cycles the synced input disagrees with the
   // filtered level; the level follows only after FILTER_LEN such cycles.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         flt_cnt <= '0;
         filt_q  <= 1'b0;
      end else if (synced == filt_q) begin
         flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
         flt_cnt <= '0;
         filt_q  <= synced;
      end else begin
         flt_cnt <= flt_cnt + 1'b1;
      end
   end

   assign level = filt_q;
`else
   assign level = synced;
`endif

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level;
      end
   end

   assign rise = level & ~level_q;
   assign fall = ~level & level_q;

endmodule

// File: rtl/switch_clock_monitor.sv
// Switch clock receiver: measures period/high time, tracks lock, flags loss.
// Ports: clk, clr_n, sw_clk_in in; period, high_time, meas_valid, locked, lost out.
// Build option: SWCLK_GLITCH_FILTER_EN enables the input glitch filter.
module switch_clock_monitor
   import swclk_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int CNT_W          = SWCLK_CNT_W,
   parameter int NOMINAL_PERIOD = SWCLK_NOMINAL_PERIOD,
   parameter int TOLERANCE      = SWCLK_TOLERANCE,
   parameter int TIMEOUT        = SWCLK_TIMEOUT,
   parameter int LOCK_COUNT     = 4,
   parameter int FILTER_LEN     = 8
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             sw_clk_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             lost
);

   localparam int GW = $clog2(LOCK_COUNT + 1);

   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
   localparam logic [CNT_W:0]   LO_LIM = (CNT_W+1)'(NOMINAL_PERIOD - TOLERANCE);
   localparam logic [CNT_W:0]   HI_LIM = (CNT_W+1)'(NOMINAL_PERIOD + TOLERANCE);
   localparam logic [GW-1:0]    LC_VAL = GW'(LOCK_COUNT);

   swclk_state_t     state;
   swclk_state_t     state_nxt;
   logic             rise;
   logic             fall;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hi_cap;
   logic             fell;
   logic [GW-1:0]    good_cnt;
   logic [GW-1:0]    good_inc;
   logic             good;

   swclk_sync_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_sync (
      .clk       (clk),
      .clr_n     (clr_n),
      .sw_clk_in (sw_clk_in),
      .rise      (rise),
      .fall      (fall)
   );

   assign good = ({1'b0, cnt} >= LO_LIM) && ({1'b0, cnt} <= HI_LIM);
   assign good_inc = (good_cnt == LC_VAL) ? LC_VAL : good_cnt + 1'b1;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state <= SEARCH;
      end else begin
         state <= state_nxt;
      end
   end

   // A rise in the timeout cycle still counts as a valid edge.
   always_comb begin
      state_nxt = state;
      unique case (state)
         SEARCH:  if (rise) state_nxt = MEASURE;
         MEASURE: if (!rise && cnt == TO_VAL) state_nxt = SEARCH;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cnt        <= '0;
         hi_cap     <= '0;
         fell       <= 1'b0;
         good_cnt   <= '0;
         period     <= '0;
         high_time  <= '0;
         meas_valid <= 1'b0;
         locked     <= 1'b0;
         lost       <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         lost       <= 1'b0;
         unique case (state)
            SEARCH: begin
               fell <= 1'b0;
               cnt  <= rise ? CNT_W'(1) : '0;
            end
            MEASURE: begin
               if (cnt != TO_VAL) cnt <= cnt + 1'b1;
               if (fall) begin
                  hi_cap <= cnt;
                  fell   <= 1'b1;
               end
               if (rise) begin
                  cnt        <= CNT_W'(1);
                  fell       <= 1'b0;
                  period     <= cnt;
                  // No fall seen this period: treat the whole period as high.
                  high_time  <= fell ? hi_cap : cnt;
                  meas_valid <= 1'b1;
                  if (good) begin
                     good_cnt <= good_inc;
                     locked   <= (good_inc == LC_VAL);
                  end else begin
                     good_cnt <= '0;
                     locked   <= 1'b0;
                     lost     <= locked;
                  end
               end else if (cnt == TO_VAL) begin
                  cnt      <= '0;
                  good_cnt <= '0;
                  locked   <= 1'b0;
                  lost     <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_switch_clock_monitor.sv
// Directed bench for switch_clock_monitor with a scaled-down nominal period
// (480 cycles, tolerance 5, timeout 960) to keep runtime short.
module tb_switch_clock_monitor;
   import swclk_pkg::*;

   localparam int CW = 17;

   logic          clk = 1'b0;
   logic          clr_n = 1'b0;
   logic          sw_clk_in = 1'b0;
   logic [CW-1:0] period;
   logic [CW-1:0] high_time;
   logic          meas_valid;
   logic          locked;
   logic          lost;

   int n_tests = 0;
   int n_fail = 0;
   int mv_cnt = 0;
   int lost_cnt = 0;
   int first_lock_mv = 0;
   int first_period = -1;
   int first_high = -1;
   int mv0;
   int lost0;

   switch_clock_monitor #(
      .SYNC_STAGES    (2),
      .CNT_W          (CW),
      .NOMINAL_PERIOD (480),
      .TOLERANCE      (5),
      .TIMEOUT        (960),
      .LOCK_COUNT     (4),
      .FILTER_LEN     (8)
   ) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .sw_clk_in  (sw_clk_in),
      .period     (period),
      .high_time  (high_time),
      .meas_valid (meas_valid),
      .locked     (locked),
      .lost       (lost)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (meas_valid) begin
         mv_cnt = mv_cnt + 1;
         if (mv_cnt == 1) begin
            first_period = int'(period);
            first_high = int'(high_time);
         end
         if (locked && first_lock_mv == 0) first_lock_mv = mv_cnt;
      end
      if (lost) lost_cnt = lost_cnt + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish within time budget");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive_period(input int hi, input int lo);
      sw_clk_in = 1'b1;
      repeat (hi) @(negedge clk);
      sw_clk_in = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   initial begin
      // Reset state
      repeat (5) @(negedge clk);
      check("rst_period", int'(period), 0);
      check("rst_high", int'(high_time), 0);
      check("rst_mv", int'(meas_valid), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_lost", int'(lost), 0);
      check("rst_state", int'(dut.state), int'(SEARCH));
      clr_n = 1'b1;
      repeat (5) @(negedge clk);

      // Ideal input, 6 periods
      drive_period(240, 240);
      check("first_rise_no_mv", mv_cnt, 0);
      repeat (5) drive_period(240, 240);
      check("ideal_mv_cnt", mv_cnt, 5);
      check("ideal_first_period", first_period, 480);
      check("ideal_first_high", first_high, 240);
      check("ideal_lock_at_mv", first_lock_mv, 4);
      check("ideal_locked", int'(locked), 1);
      check("ideal_no_lost", lost_cnt, 0);

      // One long bad period while locked, then re-lock
      drive_period(250, 250);
      drive_period(240, 240);
      check("bad_period", int'(period), 500);
      check("bad_high", int'(high_time), 250);
      check("bad_unlocked", int'(locked), 0);
      check("bad_lost_once", lost_cnt, 1);
      repeat (3) drive_period(240, 240);
      check("relock_3_good", int'(locked), 0);
      drive_period(240, 240);
      check("relock_4_good", int'(locked), 1);
      check("relock_period", int'(period), 480);

      // Input held low: timeout
      repeat (470) @(negedge clk);
      check("pre_timeout_lost", lost_cnt, 1);
      check("pre_timeout_locked", int'(locked), 1);
      repeat (30) @(negedge clk);
      check("timeout_lost", lost_cnt, 2);
      check("timeout_locked", int'(locked), 0);
      check("timeout_state", int'(dut.state), int'(SEARCH));
      check("timeout_period_hold", int'(period), 480);

      // Tolerance boundary
      repeat (5) drive_period(240, 240);
      check("bnd_locked", int'(locked), 1);
      drive_period(243, 242);
      drive_period(243, 243);
      check("bnd_485_period", int'(period), 485);
      check("bnd_485_high", int'(high_time), 243);
      check("bnd_485_locked", int'(locked), 1);
      check("bnd_485_lost", lost_cnt, 2);
      drive_period(240, 240);
      check("bnd_486_period", int'(period), 486);
      check("bnd_486_locked", int'(locked), 0);
      check("bnd_486_lost", lost_cnt, 3);

      // 3-cycle glitch in the low phase
      mv0 = mv_cnt;
      sw_clk_in = 1'b1;
      repeat (240) @(negedge clk);
      sw_clk_in = 1'b0;
      repeat (118) @(negedge clk);
      sw_clk_in = 1'b1;
      repeat (3) @(negedge clk);
      sw_clk_in = 1'b0;
      repeat (119) @(negedge clk);
      drive_period(240, 240);
`ifdef SWCLK_GLITCH_FILTER_EN
      check("glitch_mv_delta", mv_cnt - mv0, 2);
      check("glitch_period", int'(period), 480);
      check("glitch_high", int'(high_time), 240);
`else
      check("glitch_mv_delta", mv_cnt - mv0, 3);
      check("glitch_period", int'(period), 122);
      check("glitch_high", int'(high_time), 3);
`endif
      check("glitch_lost", lost_cnt, 3);

      // Reset mid-period while locked
      repeat (5) drive_period(240, 240);
      check("prerst_locked", int'(locked), 1);
      lost0 = lost_cnt;
      sw_clk_in = 1'b1;
      repeat (100) @(negedge clk);
      #2 clr_n = 1'b0;
      #1;
      check("midrst_period", int'(period), 0);
      check("midrst_high", int'(high_time), 0);
      check("midrst_mv", int'(meas_valid), 0);
      check("midrst_locked", int'(locked), 0);
      check("midrst_lost", int'(lost), 0);
      repeat (3) @(negedge clk);
      sw_clk_in = 1'b0;
      repeat (3) @(negedge clk);
      clr_n = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_no_lost_pulse", lost_cnt, lost0);
      mv0 = mv_cnt;
      drive_period(240, 240);
      check("postrst_first_rise", mv_cnt - mv0, 0);
      repeat (3) drive_period(240, 240);
      check("postrst_3_good_mv", mv_cnt - mv0, 3);
      check("postrst_3_good_lock", int'(locked), 0);
      drive_period(240, 240);
      check("postrst_4_good_lock", int'(locked), 1);
      check("postrst_period", int'(period), 480);
      check("postrst_lost", lost_cnt, lost0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/switch_clock_monitor.md
Name: switch_clock_monitor

Overview:
Receive side of the 2.083 kHz, 50 % duty switch clock that the board drives out on the high-speed PMOD (JA/JB).
- Samples an incoming switch clock asynchronous to clk (100 MHz) and synchronizes it.
- Measures period and high time in clk cycles.
- Declares lock after consecutive in-tolerance periods and flags loss on a bad period or a missing edge.
- Used for loopback checking of the switch clock output and for slaving a second board to a remote switch clock.

Parameters:
SYNC_STAGES, 2, flip-flop stages in the input synchronizer (minimum 2)
CNT_W, 17, width of the cycle counter and the measurement outputs
NOMINAL_PERIOD, 48000, expected period in clk cycles
TOLERANCE, 480, allowed |period - NOMINAL_PERIOD|, inclusive
TIMEOUT, 96000, cycles without a rising edge before loss is declared; must be less than 2^CNT_W
LOCK_COUNT, 4, consecutive in-tolerance periods needed to assert locked
FILTER_LEN, 8, stable-sample count for the optional glitch filter

Ports:
clk  input  1  100 MHz system clock
clr_n  input  1  asynchronous active-low reset
sw_clk_in  input  1  external switch clock, asynchronous to clk
period  output  CNT_W  last measured period in clk cycles
high_time  output  CNT_W  high time of the period reported in period
meas_valid  output  1  one-cycle pulse when period and high_time update
locked  output  1  level, high while locked
lost  output  1  one-cycle pulse on loss of lock or on timeout

Behaviour:
Reset (clr_n low, asynchronous):
- period=0, high_time=0, meas_valid=0, locked=0, lost=0.
- All synchronizer and filter flops are 0. FSM is in SEARCH, the counter is 0, good_cnt is 0.
- Reset asserted mid-measurement discards all partial state. No lost pulse is generated by reset.

Synchronizer and edge detect:
- SYNC_STAGES flops, then a one-flop delayed copy.
- rise = synced & ~delayed; fall = ~synced & delayed.
- An input edge is seen SYNC_STAGES+1 cycles after it occurs (3 cycles at default).

FSM, states SEARCH and MEASURE:
- SEARCH: counter held at 0. On rise: counter <= 1, go to MEASURE. No meas_valid is issued.
- MEASURE, each cycle: counter increments, saturating at TIMEOUT.
- MEASURE, on fall: hi_cap <= counter.
- MEASURE, on rise: period <= counter, high_time <= hi_cap, meas_valid pulses next cycle, counter <= 1, stay in MEASURE.
- Counter semantics: the cycle after a rise reads 1. For an ideal 48000-cycle, 50 % input, period=48000 and high_time=24000.
- A rise with no preceding fall in the same period cannot occur. If it does, high_time = period.

Timeout:
- In MEASURE, counter == TIMEOUT with no rise in that cycle: go to SEARCH, counter <= 0, good_cnt <= 0, locked <= 0, lost pulses.
- period and high_time hold their last values.
- Rise and timeout in the same cycle: the rise wins and a normal measurement is made.

Lock:
- A measured period is good if NOMINAL_PERIOD - TOLERANCE <= period <= NOMINAL_PERIOD + TOLERANCE, using unsigned compare at CNT_W+1 bits.
- Good period: good_cnt increments, saturating at LOCK_COUNT. locked <= 1 once good_cnt reaches LOCK_COUNT, i.e. in the same cycle meas_valid pulses for the LOCK_COUNT-th good period.
- Bad period: good_cnt <= 0, locked <= 0. lost pulses only if locked was 1.
- Measurement continues in both cases; the FSM stays in MEASURE.

Optional Feature:
SWCLK_GLITCH_FILTER_EN
- Defined: a filter sits between the synchronizer and edge detect. Its output changes only after the synced input has held the new value for FILTER_LEN consecutive cycles. Shorter pulses are ignored. Edge latency grows by FILTER_LEN cycles. Measured period is unaffected for clean input.
- Undefined: no filter. FILTER_LEN is unused.

Decomposition:
- Package swclk_pkg holds:
  - the FSM state typedef (SEARCH, MEASURE);
  - default constants SWCLK_NOMINAL_PERIOD=48000, SWCLK_TOLERANCE=480, SWCLK_TIMEOUT=96000, SWCLK_CNT_W=17.
- The same package is shared with the switch clock generator, so both ends use one nominal value.
- One sub-module: swclk_sync_filter. It contains the synchronizer, the optional glitch filter and the edge detector, and outputs rise and fall.

Test Plan:
- Ideal 48000-cycle, 50 % input, 6 periods:
  - first meas_valid after the 2nd input rise, with period=48000, high_time=24000;
  - locked rises with the 4th meas_valid;
  - lost never pulses.
- Locked, then one period of 50000 (outside 48000±480): meas_valid with period=50000, locked drops in that cycle, one lost pulse, good_cnt restarts; 4 more good periods re-lock.
- Locked, then input held low: at counter=96000, one lost pulse, locked=0, FSM in SEARCH; period stays 48000.
- Period 48480 (edge of tolerance) counts as good; 48481 counts as bad.
- With SWCLK_GLITCH_FILTER_EN: 3-cycle high glitch mid-low-phase is ignored and period stays 48000. Without the macro, the same stimulus causes a bad period.
- clr_n asserted mid-period while locked: all outputs are 0 immediately; after release, the first rise gives no meas_valid and lock needs 4 good periods.
